// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network blocks: class count,
// score width, FC-layer FSM states and the saturating +/-1 score step.
package bnn_pkg;

  localparam int N_CLASSES = 10;
  localparam int SCORE_W   = 10;

  localparam logic signed [SCORE_W-1:0] SCORE_MAX = 10'sh1FF;  //  511
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = 10'sh200;  // -512

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_ACCUM = 2'd1,
    FC_DONE  = 2'd2
  } fc_state_e;

  // One XNOR-popcount step: +1 on a match, -1 on a mismatch, clamped at the
  // score limits. The step is always one, so clamping at equality is exact.
  function automatic logic signed [SCORE_W-1:0] sat_step(
    input logic signed [SCORE_W-1:0] acc,
    input logic                      up
  );
    logic signed [SCORE_W-1:0] res;
    if (up) begin
      res = (acc == SCORE_MAX) ? SCORE_MAX : acc + 10'sd1;
    end else begin
      res = (acc == SCORE_MIN) ? SCORE_MIN : acc - 10'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bnn_fc_layer_if.sv
// Bus between the controller and the binary FC layer: inference control,
// feature stream, weight/bias write port and the ten class scores.
// The master modport is the controller side, the slave modport the layer.
interface bnn_fc_layer_if #(
  parameter int N_IN = 144,
  parameter int AW   = (N_IN > 1) ? $clog2(N_IN) : 1
);
  logic               start;
  logic               fc_din;
  logic               fc_din_valid;
  logic               w_wr_en;
  logic [AW-1:0]      w_wr_addr;
  logic [9:0]         w_wr_data;
  logic               b_wr_en;
  logic [3:0]         b_wr_idx;
  logic signed [9:0]  b_wr_data;
  logic signed [9:0]  fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4;
  logic signed [9:0]  fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9;
  logic               fc_result_valid;
  logic               busy;

  modport master (
    output start, fc_din, fc_din_valid,
    output w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_idx, b_wr_data,
    input  fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
    input  fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9,
    input  fc_result_valid, busy
  );

  modport slave (
    input  start, fc_din, fc_din_valid,
    input  w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_idx, b_wr_data,
    output fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
    output fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9,
    output fc_result_valid, busy
  );

endinterface

// File: rtl/fc_weight_mem.sv
// N_IN x 10 weight register file: synchronous write, combinational read.
// Contents are not reset; rows are meaningless until written.
module fc_weight_mem #(
  parameter int N_IN = 144,
  parameter int AW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [9:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [9:0]    rdata_o
);

  logic [9:0] mem_q [N_IN];

  // Store one weight row; addresses beyond the map are dropped.
  always_ff @(posedge clk) begin
    if (we_i && ({1'b0, waddr_i} < (AW+1)'(N_IN))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bnn_fc_layer.sv
// Binary fully-connected output layer: XNOR-popcount of the pooled feature
// stream against a per-feature 10-class weight row, producing ten signed
// saturating scores and a one-cycle done pulse.
// Optional feature macro: FC_BIAS_EN (per-class bias loaded on start).
module bnn_fc_layer
  import bnn_pkg::*;
#(
  parameter int N_IN  = 144,
  parameter int ACC_W = 10
) (
  input  logic           clk,
  input  logic           rstn,
  bnn_fc_layer_if.slave  bus
);

  localparam int          AW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

  fc_state_e                state_q;
  logic [AW-1:0]            cnt_q;
  logic                     valid_q;
  logic                     busy_q;
  logic signed [ACC_W-1:0]  acc_q [N_CLASSES];
  logic signed [ACC_W-1:0]  acc_d [N_CLASSES];
  logic signed [ACC_W-1:0]  init_s [N_CLASSES];
  logic [9:0]               w_row_s;
  logic                     w_we_s;

  // Weights may only change while no inference is consuming them.
  assign w_we_s = bus.w_wr_en & (state_q != FC_ACCUM);

  fc_weight_mem #(.N_IN(N_IN), .AW(AW)) u_wmem (
    .clk     (clk),
    .we_i    (w_we_s),
    .waddr_i (bus.w_wr_addr),
    .wdata_i (bus.w_wr_data),
    .raddr_i (cnt_q),
    .rdata_o (w_row_s)
  );

`ifdef FC_BIAS_EN
  logic signed [9:0] bias_q [N_CLASSES];

  // Bias registers, writable outside ACCUM, cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N_CLASSES; j++) bias_q[j] <= 10'sd0;
    end else if (bus.b_wr_en && (state_q != FC_ACCUM) && (bus.b_wr_idx < 4'd10)) begin
      bias_q[bus.b_wr_idx] <= bus.b_wr_data;
    end
  end

  // Accumulators start from the stored bias.
  always_comb begin
    for (int j = 0; j < N_CLASSES; j++) init_s[j] = bias_q[j];
  end
`else
  logic unused_bias_s;
  assign unused_bias_s = ^{bus.b_wr_en, bus.b_wr_idx, bus.b_wr_data};

  // Without bias storage every accumulator starts from zero.
  always_comb begin
    for (int j = 0; j < N_CLASSES; j++) init_s[j] = '0;
  end
`endif

  // Score datapath: start reloads, an accepted bit steps every class by +/-1.
  always_comb begin
    for (int j = 0; j < N_CLASSES; j++) acc_d[j] = acc_q[j];
    if (bus.start) begin
      for (int j = 0; j < N_CLASSES; j++) acc_d[j] = init_s[j];
    end else if ((state_q == FC_ACCUM) && bus.fc_din_valid) begin
      for (int j = 0; j < N_CLASSES; j++) begin
        acc_d[j] = sat_step(acc_q[j], ~(bus.fc_din ^ w_row_s[j]));
      end
    end else begin
      for (int j = 0; j < N_CLASSES; j++) acc_d[j] = acc_q[j];
    end
  end

  // Control FSM with registered busy/valid; start overrides everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FC_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int j = 0; j < N_CLASSES; j++) acc_q[j] <= '0;
    end else begin
      valid_q <= 1'b0;
      for (int j = 0; j < N_CLASSES; j++) acc_q[j] <= acc_d[j];
      if (bus.start) begin
        state_q <= FC_ACCUM;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          FC_ACCUM: begin
            if (bus.fc_din_valid) begin
              if (cnt_q == LAST) begin
                state_q <= FC_DONE;
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + AW'(1);
              end
            end
          end
          FC_IDLE, FC_DONE: begin
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= FC_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fc_result_0     = acc_q[0];
  assign bus.fc_result_1     = acc_q[1];
  assign bus.fc_result_2     = acc_q[2];
  assign bus.fc_result_3     = acc_q[3];
  assign bus.fc_result_4     = acc_q[4];
  assign bus.fc_result_5     = acc_q[5];
  assign bus.fc_result_6     = acc_q[6];
  assign bus.fc_result_7     = acc_q[7];
  assign bus.fc_result_8     = acc_q[8];
  assign bus.fc_result_9     = acc_q[9];
  assign bus.fc_result_valid = valid_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_bnn_fc_layer.sv
// Self-checking bench for bnn_fc_layer: expected score vectors are computed
// from a bench-side weight/bias model, queued when an inference is launched,
// and popped when the layer raises fc_result_valid.
module tb_bnn_fc_layer;

  localparam int N_IN = 144;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic [9:0]        w_m [N_IN];
  int                b_m [10];
  logic [99:0]       sb [$];

  bnn_fc_layer_if #(.N_IN(N_IN)) bus ();

  bnn_fc_layer #(.N_IN(N_IN), .ACC_W(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [99:0] dut_res();
    return {bus.fc_result_9, bus.fc_result_8, bus.fc_result_7, bus.fc_result_6,
            bus.fc_result_5, bus.fc_result_4, bus.fc_result_3, bus.fc_result_2,
            bus.fc_result_1, bus.fc_result_0};
  endfunction

  // Reference scores: sequential saturating +/-1 per feature bit.
  function automatic logic [99:0] model(input logic [N_IN-1:0] bits);
    logic [99:0] r;
    int a;
    r = '0;
    for (int j = 0; j < 10; j++) begin
      a = b_m[j];
      for (int k = 0; k < N_IN; k++) begin
        if (bits[k] == w_m[k][j]) a = (a < 511) ? a + 1 : 511;
        else                      a = (a > -512) ? a - 1 : -512;
      end
      r[j*10 +: 10] = a[9:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_weight(input int addr, input logic [9:0] data);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = addr[7:0];
    bus.w_wr_data = data;
    tick();
    bus.w_wr_en = 1'b0;
    w_m[addr] = data;
  endtask

  task automatic wr_all(input logic [9:0] data);
    for (int k = 0; k < N_IN; k++) wr_weight(k, data);
  endtask

  task automatic wr_bias(input int idx, input int val);
    bus.b_wr_en   = 1'b1;
    bus.b_wr_idx  = idx[3:0];
    bus.b_wr_data = val[9:0];
    tick();
    bus.b_wr_en = 1'b0;
`ifdef FC_BIAS_EN
    b_m[idx] = val;
`endif
  endtask

  // Start pulse (with a stray valid bit that must be discarded), nbits feature
  // bits with optional random gaps, optional weight write at bit wr_at.
  // vcyc = cycle number (start cycle = 1) in which the valid pulse is seen.
  task automatic run_infer(input logic [N_IN-1:0] bits, input int nbits, input int max_gap,
                           input int wr_at, output int vcyc, output int early);
    int edges;
    int gap;
    edges = 0; vcyc = 0; early = 0;
    bus.start = 1'b1; bus.fc_din_valid = 1'b1; bus.fc_din = 1'b0;
    tick(); edges++;
    bus.start = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.fc_din_valid = 1'b0;
        tick(); edges++;
        if (bus.fc_result_valid) early++;
      end
      bus.fc_din_valid = 1'b1;
      bus.fc_din = bits[k];
      if (k == wr_at) begin
        bus.w_wr_en = 1'b1; bus.w_wr_addr = 8'd5; bus.w_wr_data = 10'h000;
      end
      tick(); edges++;
      bus.w_wr_en = 1'b0;
      if (bus.fc_result_valid) begin
        if (k == nbits - 1 && vcyc == 0) vcyc = edges + 1;
        else early++;
      end
    end
    bus.fc_din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); edges++;
      if (bus.fc_result_valid) begin
        if (vcyc == 0) vcyc = edges + 1;
        else early++;
      end
    end
  endtask

  task automatic test_reset();
    logic [99:0] got;
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== 10'd0) begin
        errors++; $display("FAIL reset_score class%0d got %0d exp 0", j, $signed(got[j*10 +: 10]));
      end
    end
    checks++;
    if (bus.fc_result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.fc_result_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_all_ones();
    logic [99:0] exp_v, got;
    int vcyc, early;
    wr_all(10'h3FF);
    sb.push_back(model({N_IN{1'b1}}));
    run_infer({N_IN{1'b1}}, N_IN, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 146) begin errors++; $display("FAIL ones_latency got %0d exp 146", vcyc); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL ones_extra_pulse got %0d exp 0", early); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL ones class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
    repeat (8) tick();
    checks++;
    if (dut_res() !== exp_v) begin errors++; $display("FAIL ones_hold got %h exp %h", dut_res(), exp_v); end
    checks++;
    if (bus.fc_result_0 !== 10'sd144) begin errors++; $display("FAIL ones_abs got %0d exp 144", bus.fc_result_0); end
  endtask

  task automatic test_all_zeros();
    logic [99:0] exp_v, got;
    int vcyc, early;
    sb.push_back(model({N_IN{1'b0}}));
    run_infer({N_IN{1'b0}}, N_IN, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 146) begin errors++; $display("FAIL zeros_latency got %0d exp 146", vcyc); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL zeros class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
  endtask

  task automatic test_onehot();
    logic [99:0] exp_v, got;
    logic [N_IN-1:0] bits;
    logic [9:0] am;
    int vcyc, early, best;
    wr_all(10'h000);
    wr_weight(0, 10'h001);
    bits = '0; bits[0] = 1'b1;
    sb.push_back(model(bits));
    run_infer(bits, N_IN, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 146) begin errors++; $display("FAIL onehot_latency got %0d exp 146", vcyc); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL onehot class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
    best = 0;
    for (int j = 1; j < 10; j++) if ($signed(got[j*10 +: 10]) > $signed(got[best*10 +: 10])) best = j;
    am = 10'h000; am[best] = 1'b1;
    checks++;
    if (am !== 10'h001) begin errors++; $display("FAIL onehot_argmax got %h exp 001", am); end
  endtask

  task automatic test_restart();
    logic [99:0] exp_v, got;
    int vcyc, early;
    wr_all(10'h3FF);
    run_infer({N_IN{1'b1}}, 50, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 0 || early !== 0) begin errors++; $display("FAIL partial_pulse got %0d/%0d exp 0/0", vcyc, early); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL partial_busy got %b exp 1", bus.busy); end
    sb.push_back(model({N_IN{1'b1}}));
    run_infer({N_IN{1'b1}}, N_IN, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 146 || early !== 0) begin errors++; $display("FAIL restart_latency got %0d/%0d exp 146/0", vcyc, early); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL restart class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
    sb.push_back(model({N_IN{1'b1}}));
    run_infer({N_IN{1'b1}}, N_IN, 3, -1, vcyc, early);
    checks++;
    if (vcyc < 146 || early !== 0) begin errors++; $display("FAIL gaps_pulse got %0d/%0d exp >=146/0", vcyc, early); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL gaps class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
  endtask

  task automatic test_write_during_accum();
    logic [99:0] exp_v, got;
    int vcyc, early;
    for (int pass = 0; pass < 2; pass++) begin
      sb.push_back(model({N_IN{1'b1}}));
      run_infer({N_IN{1'b1}}, N_IN, 0, (pass == 0) ? 2 : -1, vcyc, early);
      checks++;
      if (vcyc !== 146) begin errors++; $display("FAIL busy_wr_latency pass%0d got %0d exp 146", pass, vcyc); end
      exp_v = sb.pop_front();
      got = dut_res();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
          errors++; $display("FAIL busy_wr pass%0d class%0d got %0d exp %0d", pass, j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [99:0] exp_v, got;
    int vcyc, early;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.fc_din = 1'b1; bus.fc_din_valid = 1'b1;
    repeat (20) tick();
    bus.fc_din_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.fc_result_0 !== 10'sd20) begin
      errors++; $display("FAIL mid_state busy %b score %0d exp 1/20", bus.busy, bus.fc_result_0);
    end
    rstn = 1'b0; #1;
    checks++;
    if (dut_res() !== 100'd0 || bus.busy !== 1'b0 || bus.fc_result_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset scores %h busy %b valid %b exp 0", dut_res(), bus.busy, bus.fc_result_valid);
    end
    tick(); rstn = 1'b1; tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle busy %b exp 0", bus.busy); end
    sb.push_back(model({N_IN{1'b1}}));
    run_infer({N_IN{1'b1}}, N_IN, 0, -1, vcyc, early);
    checks++;
    if (vcyc !== 146) begin errors++; $display("FAIL retained_latency got %0d exp 146", vcyc); end
    exp_v = sb.pop_front();
    got = dut_res();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
        errors++; $display("FAIL retained class%0d got %0d exp %0d", j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
      end
    end
  endtask

  task automatic test_bias();
    logic [99:0] exp_v, got;
    int vcyc, early;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin wr_bias(3, 5); wr_bias(7, -3); end
      else wr_bias(0, 500);
      sb.push_back(model({N_IN{1'b1}}));
      run_infer({N_IN{1'b1}}, N_IN, 0, -1, vcyc, early);
      checks++;
      if (vcyc !== 146) begin errors++; $display("FAIL bias_latency pass%0d got %0d exp 146", pass, vcyc); end
      exp_v = sb.pop_front();
      got = dut_res();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (got[j*10 +: 10] !== exp_v[j*10 +: 10]) begin
          errors++; $display("FAIL bias pass%0d class%0d got %0d exp %0d", pass, j, $signed(got[j*10 +: 10]), $signed(exp_v[j*10 +: 10]));
        end
      end
    end
`ifdef FC_BIAS_EN
    checks++;
    if (bus.fc_result_0 !== 10'sd511 || bus.fc_result_3 !== 10'sd149 || bus.fc_result_7 !== 10'sd141) begin
      errors++; $display("FAIL bias_abs got %0d/%0d/%0d exp 511/149/141", bus.fc_result_0, bus.fc_result_3, bus.fc_result_7);
    end
`else
    checks++;
    if (bus.fc_result_0 !== 10'sd144 || bus.fc_result_3 !== 10'sd144) begin
      errors++; $display("FAIL nobias_abs got %0d/%0d exp 144/144", bus.fc_result_0, bus.fc_result_3);
    end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int j = 0; j < 10; j++) b_m[j] = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.fc_din = 1'b0; bus.fc_din_valid = 1'b0;
    bus.w_wr_en = 1'b0; bus.w_wr_addr = 8'd0; bus.w_wr_data = 10'h000;
    bus.b_wr_en = 1'b0; bus.b_wr_idx = 4'd0; bus.b_wr_data = 10'sd0;
    repeat (3) tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_all_ones();
    test_all_zeros();
    test_onehot();
    test_restart();
    test_write_during_accum();
    test_reset_mid();
    test_bias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
